// File: rtl/alu_display_driver_if.sv
// rtl/alu_display_driver_if.sv - ALU snapshot inputs and seven-segment outputs of the display driver
interface alu_display_driver_if;
  logic       btn_capture;
  logic [1:0] sw_select;
  logic [2:0] a;
  logic [2:0] b;
  logic [3:0] q;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       valid;

  // master drives the ALU side and the button, slave is the display driver
  modport master (
    output btn_capture, sw_select, a, b, q,
    input  anode, seg, valid
  );

  modport slave (
    input  btn_capture, sw_select, a, b, q,
    output anode, seg, valid
  );
endinterface

// File: rtl/alu_display_driver.sv
// rtl/alu_display_driver.sv - debounced ALU snapshot shown on a 4-digit multiplexed seven-segment display
module alu_display_driver #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REFRESH_CYCLES  = 100000
) (
  input logic                clk,
  input logic                rst,
  alu_display_driver_if.slave bus
);
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [6:0]    DASH    = 7'b0111111;

  logic          sync1;
  logic          btn_sync;
  logic          btn_stable;
  logic [DW-1:0] db_cnt;
  logic          cap;
  logic [1:0]    sel_r;
  logic [2:0]    a_r;
  logic [2:0]    b_r;
  logic [3:0]    q_r;
  logic          valid_r;
  logic [RW-1:0] rf_cnt;
  logic [1:0]    idx;
  logic [3:0]    digit;
  logic [3:0]    anode_r;
  logic [6:0]    seg_r;

  // hex digit to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // two-flop synchroniser for the asynchronous push-button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync1    <= bus.btn_capture;
      btn_sync <= sync1;
    end
  end

  // accept a new level only after it holds for DEBOUNCE_CYCLES; flag the 0->1 acceptance as cap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_stable <= 1'b0;
      db_cnt     <= '0;
      cap        <= 1'b0;
    end else begin
      cap <= 1'b0;
      if (btn_sync == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_stable <= btn_sync;
        db_cnt     <= '0;
        cap        <= btn_sync;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  // snapshot the live ALU signals on the cap pulse; valid latches once any capture happened
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      q_r     <= '0;
      valid_r <= 1'b0;
    end else if (cap) begin
      sel_r   <= bus.sw_select;
      a_r     <= bus.a;
      b_r     <= bus.b;
      q_r     <= bus.q;
      valid_r <= 1'b1;
    end
  end

  // refresh timer; each wrap advances to the next digit, 3 rolls back to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_cnt <= '0;
      idx    <= 2'd0;
    end else if (rf_cnt == RF_LAST) begin
      rf_cnt <= '0;
      idx    <= idx + 2'd1;
    end else begin
      rf_cnt <= rf_cnt + RW'(1);
    end
  end

  // pick the snapshot field belonging to the currently scanned digit
  always_comb begin
    digit = q_r;
    case (idx)
      2'd0: digit = q_r;
      2'd1: digit = {1'b0, b_r};
      2'd2: digit = {1'b0, a_r};
      default: digit = {2'b00, sel_r};
    endcase
  end

  // registered digit drive, one cycle behind idx; dashes until the first capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_r <= 4'b1110;
      seg_r   <= DASH;
    end else begin
      anode_r <= ~(4'b0001 << idx);
      seg_r   <= valid_r ? hex7(digit) : DASH;
    end
  end

  assign bus.anode = anode_r;
  assign bus.seg   = seg_r;
  assign bus.valid = valid_r;
endmodule

// File: tb/tb_alu_display_driver.sv
// tb/tb_alu_display_driver.sv - self-checking bench for alu_display_driver
module tb_alu_display_driver;
  localparam int D = 4;
  localparam int R = 8;
  localparam logic [6:0] DASH = 7'b0111111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_display_driver_if bus ();

  alu_display_driver #(.DEBOUNCE_CYCLES(D), .REFRESH_CYCLES(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: edge-counted scan, run-length debounce, snapshot on the edge after acceptance
  logic [6:0] hex_tab [16];
  int         n;
  bit [1:0]   hist;
  bit         stable_m;
  int         run;
  bit         cap_m;
  bit         valid_m;
  int         snap_sel, snap_a, snap_b, snap_q;
  logic [3:0] anode_e;
  logic [6:0] seg_e;

  task automatic model_reset();
    n = 0; hist = 2'b00; stable_m = 1'b0; run = 0; cap_m = 1'b0; valid_m = 1'b0;
    snap_sel = 0; snap_a = 0; snap_b = 0; snap_q = 0;
    anode_e = 4'b1110; seg_e = DASH;
  endtask

  function automatic int digit_of(input int i);
    case (i)
      0: return snap_q;
      1: return snap_b;
      2: return snap_a;
      default: return snap_sel;
    endcase
  endfunction

  task automatic model_step();
    int  idx;
    bit  sync_v;
    idx     = (n / R) % 4;
    anode_e = ~(4'b0001 << idx);
    seg_e   = valid_m ? hex_tab[digit_of(idx)] : DASH;
    if (cap_m) begin
      snap_sel = int'(bus.sw_select); snap_a = int'(bus.a);
      snap_b = int'(bus.b); snap_q = int'(bus.q);
      valid_m = 1'b1;
      cap_m = 1'b0;
    end
    sync_v = hist[1];
    if (sync_v != stable_m) begin
      run++;
      if (run == D) begin
        stable_m = sync_v;
        run = 0;
        if (sync_v) cap_m = 1'b1;
      end
    end else begin
      run = 0;
    end
    hist = {hist[0], bus.btn_capture};
    n++;
  endtask

  // continuous model comparison on every falling edge
  initial begin
    hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      #1;
      if (rst) model_reset();
      chk("model_anode", 32'(bus.anode), 32'(anode_e));
      chk("model_seg", 32'(bus.seg), 32'(seg_e));
      chk("model_valid", 32'(bus.valid), 32'(valid_m));
    end
  end

  typedef struct {
    logic [1:0]      sel;
    logic [2:0]      a;
    logic [2:0]      b;
    logic [3:0]      q;
    logic [3:0][6:0] seg_exp;
  } vec_t;

  vec_t vecs [5];

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic scramble();
    bus.sw_select = 2'($urandom);
    bus.a = 3'($urandom);
    bus.b = 3'($urandom);
    bus.q = 4'($urandom);
  endtask

  // scan one full display rotation and compare each digit the first time it lights
  task automatic check_digits(input logic [3:0][6:0] exp, input int v);
    logic [3:0] seen = 4'b0000;
    for (int c = 0; c < 4 * R + 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (bus.anode == ~(4'b0001 << i) && !seen[i]) begin
          seen[i] = 1'b1;
          chk($sformatf("vec%0d_digit%0d", v, i), 32'(bus.seg), 32'(exp[i]));
        end
      end
    end
    chk($sformatf("vec%0d_all_digits_lit", v), 32'(seen), 32'hF);
  endtask

  initial begin
    int k;
    vecs[0] = '{2'd0, 3'd3, 3'd5, 4'h8, {7'b1000000, 7'b0110000, 7'b0010010, 7'b0000000}};
    vecs[1] = '{2'd0, 3'd3, 3'd5, 4'hF, {7'b1000000, 7'b0110000, 7'b0010010, 7'b0001110}};
    vecs[2] = '{2'd3, 3'd7, 3'd7, 4'h1, {7'b0110000, 7'b1111000, 7'b1111000, 7'b1111001}};
    vecs[3] = '{2'd1, 3'd0, 3'd2, 4'hF, {7'b1111001, 7'b1000000, 7'b0100100, 7'b0001110}};
    vecs[4] = '{2'd2, 3'd4, 3'd6, 4'hA, {7'b0100100, 7'b0011001, 7'b0000010, 7'b0001000}};

    bus.btn_capture = 1'b0;
    bus.sw_select = 2'd0; bus.a = 3'd0; bus.b = 3'd0; bus.q = 4'd0;
    rst = 1'b1;
    cyc(3);
    chk("reset_anode", 32'(bus.anode), 32'h0000000E);
    chk("reset_seg", 32'(bus.seg), 32'(DASH));
    chk("reset_valid", 32'(bus.valid), 32'h0);
    rst = 1'b0;

    // idle scan with no button: dashes only
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      scramble();
    end
    chk("idle_seg_dash", 32'(bus.seg), 32'(DASH));
    chk("idle_valid", 32'(bus.valid), 32'h0);

    // bounce shorter than the debounce window never captures
    for (int c = 0; c < 10; c++) begin
      bus.btn_capture = ~bus.btn_capture;
      cyc(2);
    end
    bus.btn_capture = 1'b0;
    cyc(10);
    chk("bounce_no_capture", 32'(bus.valid), 32'h0);

    // table of clean captures, each held while the live inputs keep moving
    for (int v = 0; v < 5; v++) begin
      bus.sw_select = vecs[v].sel; bus.a = vecs[v].a; bus.b = vecs[v].b; bus.q = vecs[v].q;
      bus.btn_capture = 1'b1;
      if (v == 0) begin
        k = 0;
        while (k < 30 && bus.valid !== 1'b1) begin
          @(negedge clk);
          k++;
        end
        chk("press_latency", 32'(k), 32'd7);
        cyc(1);
      end else begin
        cyc(8);
      end
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (v == 0) bus.q = 4'($urandom_range(8, 15));
        else scramble();
      end
      check_digits(vecs[v].seg_exp, v);
      bus.btn_capture = 1'b0;
      cyc(10);
    end

    // reset in the middle of a debounce window
    bus.btn_capture = 1'b1;
    cyc(3);
    rst = 1'b1;
    #1;
    chk("midrst_anode", 32'(bus.anode), 32'h0000000E);
    chk("midrst_seg", 32'(bus.seg), 32'(DASH));
    chk("midrst_valid", 32'(bus.valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (k < 30 && bus.valid !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_capture_latency", 32'(k), 32'd7);
    cyc(20);
    bus.btn_capture = 1'b0;
    cyc(10);

    // randomized button activity and live inputs against the model
    for (int c = 0; c < 1500; ) begin
      int hold = $urandom_range(1, 10);
      bus.btn_capture = 1'($urandom);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        scramble();
        if ($urandom_range(0, 299) == 0) rst = 1'b1;
        else rst = 1'b0;
        c++;
      end
    end
    rst = 1'b0;
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end
endmodule
